// File: rtl/serial_nibble_rx_if.sv
// Bus bundle for serial_nibble_rx: line, strobe, consumer handshake and status.
// Par_Err exists only when RX_PARITY_EN is defined.
interface serial_nibble_rx_if #(
  parameter int DATA_W = 4
);
  logic              Bit_Tick;
  logic              Ser_In;
  logic              Dir;
  logic              Rd;
  logic              Clr_Err;
  logic [DATA_W-1:0] Dout;
  logic              Valid;
  logic              Busy;
  logic              Frame_Err;
  logic              Overrun;
`ifdef RX_PARITY_EN
  logic              Par_Err;
`endif

  modport master (
    output Bit_Tick, Ser_In, Dir, Rd, Clr_Err,
    input  Dout, Valid, Busy, Frame_Err, Overrun
`ifdef RX_PARITY_EN
    , input Par_Err
`endif
  );

  modport slave (
    input  Bit_Tick, Ser_In, Dir, Rd, Clr_Err,
    output Dout, Valid, Busy, Frame_Err, Overrun
`ifdef RX_PARITY_EN
    , output Par_Err
`endif
  );
endinterface

// File: rtl/serial_nibble_rx.sv
// Start/data/stop receiver for the shift-register nibble link, with a one-entry
// valid/read buffer and sticky errors. Define RX_PARITY_EN for an even-parity bit.
module serial_nibble_rx #(
  parameter int DATA_W = 4
) (
  input logic              Ck,
  input logic              Reset,
  serial_nibble_rx_if.slave bus
);
  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
`ifdef RX_PARITY_EN
    PAR,
`endif
    STOP,
    BRK
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [CW-1:0]     cnt;
  logic              dir_q;
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;
  logic              busy_q;
  logic              ferr_q;
  logic              ovr_q;
  logic              bad_q;
`ifdef RX_PARITY_EN
  logic              perr_q;
  assign bus.Par_Err = perr_q;
`else
  assign bad_q = 1'b0;
`endif

  assign bus.Dout      = dout_q;
  assign bus.Valid     = valid_q;
  assign bus.Busy      = busy_q;
  assign bus.Frame_Err = ferr_q;
  assign bus.Overrun   = ovr_q;

  // Pop and clear are applied first so that a delivery or a new error
  // later in the same block overrides them.
  always_ff @(posedge Ck) begin
    if (Reset) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef RX_PARITY_EN
      perr_q  <= 1'b0;
      bad_q   <= 1'b0;
`endif
    end else begin
      if (bus.Rd && valid_q) valid_q <= 1'b0;
      if (bus.Clr_Err) begin
        ferr_q <= 1'b0;
        ovr_q  <= 1'b0;
`ifdef RX_PARITY_EN
        perr_q <= 1'b0;
`endif
      end
      if (bus.Bit_Tick) begin
        case (state)
          IDLE: begin
            if (!bus.Ser_In) begin
              dir_q  <= bus.Dir;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= DATA;
`ifdef RX_PARITY_EN
              bad_q  <= 1'b0;
`endif
            end
          end
          DATA: begin
            sh  <= dir_q ? {bus.Ser_In, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], bus.Ser_In};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DATA_W - 1)) begin
`ifdef RX_PARITY_EN
              state <= PAR;
`else
              state <= STOP;
`endif
            end
          end
`ifdef RX_PARITY_EN
          PAR: begin
            if (^sh ^ bus.Ser_In) begin
              perr_q <= 1'b1;
              bad_q  <= 1'b1;
            end
            state <= STOP;
          end
`endif
          STOP: begin
            if (bus.Ser_In) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              if (!bad_q) begin
                if (!valid_q || bus.Rd) begin
                  dout_q  <= sh;
                  valid_q <= 1'b1;
                end else begin
                  ovr_q <= 1'b1;
                end
              end
            end else begin
              ferr_q <= 1'b1;
              state  <= BRK;
            end
          end
          BRK: begin
            if (bus.Ser_In) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
